// File: rtl/ugemm_tx_pkg.sv
// ugemm_tx_pkg: shared types and helpers for the unary GEMM west-edge transmitters.
//   tx_state_t - transmitter FSM state encoding
//   DefCwidth  - default log2 of the maximum bitstream length
//   eff_len()  - maps a raw cfg_len field to the effective stream length L (1..2^cwidth)
package ugemm_tx_pkg;

    localparam int unsigned DefCwidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StClr,
        StStream,
        StDone
    } tx_state_t;

    // Zero and anything above 2^cwidth both select the full-length stream.
    function automatic int unsigned eff_len(input int unsigned cfg_len,
                                            input int unsigned cwidth);
        int unsigned max_len;
        max_len = 32'd1 << cwidth;
        if (cfg_len == 0 || cfg_len > max_len) begin
            return max_len;
        end
        return cfg_len;
    endfunction

endpackage

// File: rtl/ugemm_rng_src.sv
// ugemm_rng_src: comparison-sequence source for the rate coder.
// Holds the stream index counter k and presents rng(k).
// Optional build macro: IFM_TX_BITREV_EN -> rng is the bit-reverse of k (van der Corput
// order); otherwise rng = k.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset (k <= 0)
//   clr   - restart the sequence (k <= 0)
//   en    - advance k by one
//   rng   - current comparison value rng(k)
module ugemm_rng_src #(
    parameter int unsigned CWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [CWIDTH-1:0] rng
);

    logic [CWIDTH-1:0] k_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q <= '0;
        end else if (clr) begin
            k_q <= '0;
        end else if (en) begin
            k_q <= k_q + CWIDTH'(1);
        end
    end

`ifdef IFM_TX_BITREV_EN
    always_comb begin
        rng = '0;
        for (int i = 0; i < int'(CWIDTH); i++) begin
            rng[i] = k_q[int'(CWIDTH) - 1 - i];
        end
    end
`else
    assign rng = k_q;
`endif

endmodule

// File: rtl/ifm_unary_tx.sv
// ifm_unary_tx: west-edge transmitter for one row of the unary systolic GEMM array.
// Accepts an operand over valid/ready, then emits one clr_i cycle, L rate-coded bits on
// ifm_dff with en_i high, and one mac_done cycle. A new operand may be accepted in the
// mac_done cycle, so back-to-back operands have no bubble.
// Optional build macro: IFM_TX_BITREV_EN (bit-reversed comparison sequence, see ugemm_rng_src).
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   in_valid/in_ready - operand handshake (in_ready decoded from state only)
//   in_data           - operand; the top CWIDTH bits form the magnitude
//   cfg_len           - stream length, latched with the operand (0 or >2^CWIDTH = 2^CWIDTH)
//   ifm_dff           - rate-coded bit to the first PE
//   en_i, clr_i       - PE input-register enable / clear
//   mac_done          - end-of-MAC strobe
//   busy              - high whenever the FSM is not idle
module ifm_unary_tx
    import ugemm_tx_pkg::*;
#(
    parameter int unsigned IWIDTH = 16,
    parameter int unsigned CWIDTH = DefCwidth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IWIDTH-1:0] in_data,
    input  logic [CWIDTH:0]   cfg_len,
    output logic              ifm_dff,
    output logic              en_i,
    output logic              clr_i,
    output logic              mac_done,
    output logic              busy
);

    tx_state_t         state_q, state_d;
    logic [CWIDTH-1:0] mag_q, mag_d;
    logic [CWIDTH-1:0] rem_q, rem_d;     // bits left to issue after the current one
    logic              last_q, last_d;   // the bit now on ifm_dff is the final one
    logic              live_q;           // gates in_ready off during the reset cycle
    logic              ifm_q, en_q, clr_q, done_q, busy_q;
    logic              accept;
    logic              issue;            // a stream bit is registered at this edge
    logic [CWIDTH-1:0] rng;

    logic unused_data_lo;
    assign unused_data_lo = ^in_data[IWIDTH-CWIDTH-1:0];

    assign in_ready = live_q && (state_q == StIdle || state_q == StDone);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        rem_d   = rem_q;
        last_d  = last_q;
        issue   = 1'b0;

        case (state_q)
            StIdle:   if (accept) state_d = StClr;
            StClr: begin
                issue   = 1'b1;
                state_d = StStream;
            end
            StStream: begin
                if (last_q) begin
                    state_d = StDone;
                end else begin
                    issue = 1'b1;
                end
            end
            StDone:   state_d = accept ? StClr : StIdle;
            default:  state_d = StIdle;
        endcase

        if (accept) begin
            mag_d  = in_data[IWIDTH-1 -: CWIDTH];
            rem_d  = CWIDTH'(eff_len(32'(cfg_len), CWIDTH) - 32'd1);
            last_d = 1'b0;
        end
        if (issue) begin
            last_d = (rem_q == '0);
            rem_d  = rem_q - CWIDTH'(1);
        end
    end

    // Counter is cleared at acceptance so it already reads 0 while in CLR, where the
    // first bit is registered.
    ugemm_rng_src #(
        .CWIDTH (CWIDTH)
    ) u_rng_src (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (issue),
        .rng   (rng)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mag_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            live_q  <= 1'b0;
            ifm_q   <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            live_q  <= 1'b1;
            ifm_q   <= issue && (mag_q > rng);
            en_q    <= issue;
            clr_q   <= (state_d == StClr);
            done_q  <= (state_d == StDone);
            busy_q  <= (state_d != StIdle);
        end
    end

    assign ifm_dff  = ifm_q;
    assign en_i     = en_q;
    assign clr_i    = clr_q;
    assign mac_done = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ifm_unary_tx.sv
module tb_ifm_unary_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [8:0]  cfg_len = '0;
    logic        ifm_dff, en_i, clr_i, mac_done, busy;

    int checks = 0;
    int errors = 0;

    ifm_unary_tx #(
        .IWIDTH (16),
        .CWIDTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .cfg_len  (cfg_len),
        .ifm_dff  (ifm_dff),
        .en_i     (en_i),
        .clr_i    (clr_i),
        .mac_done (mac_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Presents one operand (called #1 after an edge with in_ready high) and captures the
    // resulting stream. lat = cycles from acceptance to the mac_done cycle.
    task automatic do_op(input logic [15:0] d, input logic [8:0] len,
                         output logic clr_seen, output int n_en, output int ones,
                         output logic [255:0] bits, output int lat);
        bits = '0;
        n_en = 0;
        ones = 0;
        in_data  = d;
        cfg_len  = len;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        clr_seen = clr_i;
        while (!mac_done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (en_i) begin
                if (n_en < 256) bits[n_en] = ifm_dff;
                n_en++;
                if (ifm_dff) ones++;
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        repeat (2) @(posedge clk);
        #1;
        outs = {ifm_dff, en_i, clr_i, mac_done, busy};
        checks++;
        if (outs !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000", outs);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got ready=%b busy=%b expected ready=1 busy=0",
                     in_ready, busy);
        end
    endtask

    task automatic test_half();
        logic clr_seen;
        int n_en, ones, lat;
        logic [255:0] bits;
        logic [255:0] exp_bits;
        exp_bits = {{128{1'b0}}, {128{1'b1}}};
        do_op(16'h8000, 9'd0, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (clr_seen !== 1'b1) begin
            errors++;
            $display("FAIL half_clr: got %b expected 1", clr_seen);
        end
        checks++;
        if (n_en != 256 || ones != 128) begin
            errors++;
            $display("FAIL half_counts: got en=%0d ones=%0d expected en=256 ones=128", n_en, ones);
        end
        checks++;
        if (bits !== exp_bits) begin
            errors++;
            $display("FAIL half_bits: got %h expected %h", bits, exp_bits);
        end
        checks++;
        if (lat != 258 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL half_done: got lat=%0d ready=%b expected lat=258 ready=1", lat, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || mac_done !== 1'b0) begin
            errors++;
            $display("FAIL half_idle: got busy=%b done=%b expected 0 0", busy, mac_done);
        end
    endtask

    task automatic test_extremes();
        logic clr_seen;
        int n_en, ones, lat;
        logic [255:0] bits;
        do_op(16'h0000, 9'd0, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (n_en != 256 || ones != 0) begin
            errors++;
            $display("FAIL zero_mag: got en=%0d ones=%0d expected en=256 ones=0", n_en, ones);
        end
        do_op(16'hFFFF, 9'd0, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (n_en != 256 || ones != 255) begin
            errors++;
            $display("FAIL max_mag: got en=%0d ones=%0d expected en=256 ones=255", n_en, ones);
        end
        checks++;
        if (bits[255] !== 1'b0 || bits[254] !== 1'b1) begin
            errors++;
            $display("FAIL max_mag_tail: got %b%b expected 01", bits[255], bits[254]);
        end
    endtask

    task automatic test_trunc();
        logic clr_seen;
        int n_en, ones, lat;
        logic [255:0] bits;
        do_op(16'h4000, 9'd16, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (n_en != 16 || bits[15:0] !== 16'hFFFF || bits[255:16] !== '0) begin
            errors++;
            $display("FAIL trunc16: got en=%0d bits=%h expected en=16 bits=ffff", n_en, bits[15:0]);
        end
        checks++;
        if (lat != 18) begin
            errors++;
            $display("FAIL trunc16_latency: got %0d expected 18", lat);
        end
        do_op(16'h0500, 9'd16, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (ones != 5 || n_en != 16) begin
            errors++;
            $display("FAIL trunc_small_mag: got ones=%0d en=%0d expected 5 16", ones, n_en);
        end
        do_op(16'h1000, 9'd300, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (ones != 16 || n_en != 256) begin
            errors++;
            $display("FAIL len_over_max: got ones=%0d en=%0d expected 16 256", ones, n_en);
        end
        do_op(16'hFF00, 9'd1, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (ones != 1 || n_en != 1 || lat != 3) begin
            errors++;
            $display("FAIL len_one: got ones=%0d en=%0d lat=%0d expected 1 1 3", ones, n_en, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] o_clr, o_en, o_done, o_ifm;
        o_clr = '0; o_en = '0; o_done = '0; o_ifm = '0;
        @(posedge clk); #1;
        in_data  = 16'hFF00;
        cfg_len  = 9'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Second operand held from here; mid-stream changes must not reach the first one.
        in_data = 16'h0000;
        cfg_len = 9'd2;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            o_clr[c]  = clr_i;
            o_en[c]   = en_i;
            o_done[c] = mac_done;
            o_ifm[c]  = ifm_dff;
            if (c == 6) in_valid = 1'b0;
        end
        checks++;
        if (o_clr !== 10'b0001000001) begin
            errors++;
            $display("FAIL b2b_clr: got %b expected 0001000001", o_clr);
        end
        checks++;
        if (o_en !== 10'b0110011110) begin
            errors++;
            $display("FAIL b2b_en: got %b expected 0110011110", o_en);
        end
        checks++;
        if (o_done !== 10'b1000100000) begin
            errors++;
            $display("FAIL b2b_done: got %b expected 1000100000", o_done);
        end
        checks++;
        if (o_ifm !== 10'b0000011110) begin
            errors++;
            $display("FAIL b2b_ifm: got %b expected 0000011110", o_ifm);
        end
    endtask

    task automatic test_reset_mid();
        int n_en, guard, done_seen;
        logic clr_seen;
        int ones, lat;
        logic [255:0] bits;
        logic [4:0] outs;
        @(posedge clk); #1;
        in_data  = 16'hFFFF;
        cfg_len  = 9'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_en = 0;
        guard = 0;
        while (n_en < 50 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
            if (en_i) n_en++;
        end
        checks++;
        if (n_en != 50) begin
            errors++;
            $display("FAIL mid_reach50: got %0d expected 50", n_en);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        outs = {ifm_dff, en_i, clr_i, mac_done, busy};
        checks++;
        if (outs !== 5'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b ready=%b expected 00000 ready=0", outs, in_ready);
        end
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (mac_done) done_seen++;
        end
        checks++;
        if (done_seen != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_done: got done=%0d ready=%b expected 0 1", done_seen, in_ready);
        end
        do_op(16'h8000, 9'd8, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (n_en != 8 || ones != 8 || lat != 10) begin
            errors++;
            $display("FAIL mid_recover: got en=%0d ones=%0d lat=%0d expected 8 8 10", n_en, ones, lat);
        end
    endtask

`ifdef IFM_TX_BITREV_EN
    task automatic test_bitrev();
        logic clr_seen;
        int n_en, ones, lat;
        logic [255:0] bits;
        logic [255:0] exp_bits;
        exp_bits = {128{2'b01}};
        do_op(16'h8000, 9'd0, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (ones != 128 || bits !== exp_bits) begin
            errors++;
            $display("FAIL bitrev_full: got ones=%0d bits=%h expected 128 %h", ones, bits, exp_bits);
        end
        do_op(16'h8000, 9'd4, clr_seen, n_en, ones, bits, lat);
        checks++;
        if (n_en != 4 || bits[3:0] !== 4'b0101) begin
            errors++;
            $display("FAIL bitrev_len4: got en=%0d bits=%b expected 4 0101", n_en, bits[3:0]);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef IFM_TX_BITREV_EN
        test_bitrev();
        test_extremes();
`else
        test_half();
        test_extremes();
        test_trunc();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifm_unary_tx.md
Name: ifm_unary_tx

Overview:
West-edge transmitter for one row of the unary systolic GEMM array. It accepts binary input-feature-map operands over a valid/ready handshake and converts each one into a rate-coded bitstream on ifm_dff. It also generates the matching per-row control sequence: en_i, clr_i and mac_done. These feed the first PE of the row, which then forwards them east with one cycle of delay per PE.

Parameters:
IWIDTH, 16, operand width in bits (unsigned magnitude)
CWIDTH, 8, log2 of the maximum bitstream length; the top CWIDTH bits of the operand are encoded

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  transmitter can accept an operand
in_data  in  IWIDTH  operand, unsigned
cfg_len  in  CWIDTH+1  stream length; latched with the operand; 0 or values above 2^CWIDTH mean 2^CWIDTH
ifm_dff  out  1  rate-coded bit to PE
en_i  out  1  PE input-register enable
clr_i  out  1  PE input-register clear
mac_done  out  1  end-of-MAC strobe to PE
busy  out  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset, sampled while rst_n=0 at a posedge:
  - state=IDLE, counter=0.
  - ifm_dff=0, en_i=0, clr_i=0, mac_done=0, busy=0.
  - in_ready=0 during the reset cycle; in_ready=1 from the first cycle after reset is released.
- All outputs are registered, with no combinational paths from inputs to outputs. The exception is in_ready, which is decoded from the state register only.
- Handshake:
  - An operand is accepted on a posedge where in_valid&in_ready=1.
  - in_ready=1 only in IDLE and DONE.
  - in_data and cfg_len are sampled only at acceptance. mag = in_data[IWIDTH-1 -: CWIDTH]. L = effective length, range 1..2^CWIDTH.
- FSM states: IDLE, CLR, STREAM, DONE.
  - IDLE: all control outputs 0. On accept -> CLR.
  - CLR: one cycle; clr_i=1, en_i=0, ifm_dff=0; counter k <= 0. Next state STREAM.
  - STREAM: L cycles; en_i=1, ifm_dff = (mag > rng(k)), k increments each cycle. When k = L-1 -> DONE.
  - DONE: one cycle; mac_done=1, en_i=0, ifm_dff=0. On accept -> CLR (back-to-back, no bubble); otherwise -> IDLE.
- Latency: with acceptance at edge T, the output values are:
  - clr_i=1 in cycle T+1.
  - Stream bits in cycles T+2..T+1+L.
  - mac_done in cycle T+2+L.
- Sustained throughput is one operand per L+2 cycles.
- rng(k) = k, the CWIDTH-bit counter value (default build).
- Full-length stream, L=2^CWIDTH: the number of ones equals mag exactly. mag=0 produces all zeros; mag=2^CWIDTH-1 produces a single 0 in the last bit.
- Truncated stream with the counter sequence: ones = min(mag, L).
- Counter wrap: k never wraps inside a stream; it is reset in CLR.
- in_valid asserted outside IDLE/DONE is ignored and in_data is not sampled.
- Reset mid-stream: the block returns to IDLE within the same edge. No mac_done is emitted for the aborted operand.
- Simultaneous events: rst_n=0 overrides acceptance.

Optional Feature:
Macro IFM_TX_BITREV_EN.
- Defined: rng(k) = bit-reverse of the CWIDTH-bit k (van der Corput low-discrepancy order). The full-length ones count is unchanged (= mag). Truncated streams approximate mag*L/2^CWIDTH rather than min(mag, L).
- Undefined: rng(k) = k.

Decomposition:
- Package ugemm_tx_pkg holds:
  - the state enum tx_state_t (IDLE, CLR, STREAM, DONE);
  - default CWIDTH;
  - function eff_len(), which maps cfg_len to L.
- One sub-module, ugemm_rng_src (parameter CWIDTH; ports clk, rst_n, clr, en, rng[CWIDTH-1:0]). It holds the counter k and applies the optional bit-reversal.

Test Plan:
- Reset, then in_data=0x8000, cfg_len=0, default build, CWIDTH=8 -> clr_i for 1 cycle, then 256 en_i cycles: first 128 bits 1, next 128 bits 0; then mac_done=1 for 1 cycle; in_ready=1 again.
- in_data=0x0000 and in_data=0xFFFF, full length -> 0 ones and 255 ones respectively (last bit 0); en_i count = 256 in each case.
- in_data=0x4000 (mag=64), cfg_len=16 -> 16 en_i cycles, all 16 bits 1, mac_done at T+18.
- Two operands with in_valid held high: second accepted in the DONE cycle -> clr_i in the cycle right after mac_done, no idle gap.
- rst_n=0 at stream cycle 50 -> all outputs 0 next cycle, no mac_done emitted, in_ready=1 after release; a new operand then streams normally.
- With IFM_TX_BITREV_EN, mag=0x80, full length -> bits alternate 1,0,1,0…, 128 ones total; with cfg_len=4 -> 1,0,1,0.
